// File: rtl/tpu_host_sequencer_if.sv
// Host byte streams plus the matrix controller's load/readout port, as seen by tpu_host_sequencer.
interface tpu_host_sequencer_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       load_en;
    logic       load_sel_ab;
    logic [1:0] load_index;
    logic [7:0] load_data;
    logic       ctrl_done;
    logic       output_en;
    logic [1:0] output_sel;
    logic [7:0] ctrl_out_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;

    modport master (
        input  s_valid, s_data, ctrl_done, ctrl_out_data, m_ready,
        output s_ready, load_en, load_sel_ab, load_index, load_data,
               output_en, output_sel, m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, ctrl_done, ctrl_out_data, m_ready,
        input  s_ready, load_en, load_sel_ab, load_index, load_data,
               output_en, output_sel, m_valid, m_data, m_last
    );
endinterface

// File: rtl/tpu_host_sequencer.sv
// Host-side sequencer: streams one 8-byte job into the 2x2 matmul controller,
// waits for done, reads back the four results and streams them out.
module tpu_host_sequencer #(
    parameter int unsigned READ_DELAY   = 2,
    parameter int unsigned DONE_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    tpu_host_sequencer_if.master        bus,
    output logic                        busy,
    output logic                        err
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_DELAY     = 3'd3,
        ST_READ      = 3'd4,
        ST_SEND      = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(DONE_TIMEOUT - 1);
    localparam logic [7:0] DELAY_LAST   = 8'(READ_DELAY - 1);

    state_t     r_state;
    logic [2:0] r_k;
    logic [7:0] r_cnt;
    logic [1:0] r_i;
    logic [7:0] r_buf [4];
    logic       r_s_ready;
    logic       r_load_en;
    logic       r_load_sel_ab;
    logic [1:0] r_load_index;
    logic [7:0] r_load_data;
    logic       r_output_en;
    logic [1:0] r_output_sel;
    logic       r_m_valid;
    logic [7:0] r_m_data;
    logic       r_m_last;
    logic       r_err;
    logic       w_accept;

    assign w_accept         = bus.s_valid && r_s_ready;
    assign bus.s_ready      = r_s_ready;
    assign bus.load_en      = r_load_en;
    assign bus.load_sel_ab  = r_load_sel_ab;
    assign bus.load_index   = r_load_index;
    assign bus.load_data    = r_load_data;
    assign bus.output_en    = r_output_en;
    assign bus.output_sel   = r_output_sel;
    assign bus.m_valid      = r_m_valid;
    assign bus.m_data       = r_m_data;
    assign bus.m_last       = r_m_last;
    assign busy             = (r_state != ST_IDLE);
    assign err              = r_err;

    // Job sequencer: state, counters, result buffer and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_k           <= 3'd0;
            r_cnt         <= 8'd0;
            r_i           <= 2'd0;
            for (int j = 0; j < 4; j++) r_buf[j] <= 8'd0;
            r_s_ready     <= 1'b0;
            r_load_en     <= 1'b0;
            r_load_sel_ab <= 1'b0;
            r_load_index  <= 2'd0;
            r_load_data   <= 8'd0;
            r_output_en   <= 1'b0;
            r_output_sel  <= 2'd0;
            r_m_valid     <= 1'b0;
            r_m_data      <= 8'd0;
            r_m_last      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_load_en <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        r_load_en     <= 1'b1;
                        r_load_sel_ab <= r_k[2];
                        r_load_index  <= r_k[1:0];
                        r_load_data   <= bus.s_data;
                        r_k           <= r_k + 3'd1;
                        r_state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // s_ready already dropped: this is the 8th byte's load_en cycle
                    if (!r_s_ready) begin
                        r_state <= ST_WAIT_DONE;
                        r_cnt   <= 8'd0;
                    end else if (w_accept) begin
                        r_load_en     <= 1'b1;
                        r_load_sel_ab <= r_k[2];
                        r_load_index  <= r_k[1:0];
                        r_load_data   <= bus.s_data;
                        r_k           <= r_k + 3'd1;
                        if (r_k == 3'd7) r_s_ready <= 1'b0;
                    end
                end
                ST_WAIT_DONE: begin
                    // done wins over a timeout expiring in the same cycle
                    if (bus.ctrl_done) begin
                        r_state <= ST_DELAY;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_s_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == DELAY_LAST) begin
                        r_state      <= ST_READ;
                        r_output_en  <= 1'b1;
                        r_output_sel <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_READ: begin
                    r_buf[r_output_sel] <= bus.ctrl_out_data;
                    if (r_output_sel == 2'd3) begin
                        r_output_en  <= 1'b0;
                        r_output_sel <= 2'd0;
                        r_state      <= ST_SEND;
                        r_m_valid    <= 1'b1;
                        r_m_data     <= r_buf[0];
                        r_m_last     <= 1'b0;
                        r_i          <= 2'd0;
                    end else begin
                        r_output_sel <= r_output_sel + 2'd1;
                    end
                end
                ST_SEND: begin
                    if (bus.m_ready) begin
                        if (r_i == 2'd3) begin
                            r_m_valid <= 1'b0;
                            r_m_data  <= 8'd0;
                            r_m_last  <= 1'b0;
                            r_state   <= ST_IDLE;
                            r_s_ready <= 1'b1;
                        end else begin
                            r_i      <= r_i + 2'd1;
                            r_m_data <= r_buf[r_i + 2'd1];
                            r_m_last <= (r_i == 2'd2);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/tpu_host_sequencer.md
# tpu_host_sequencer

Host-side driver for the 2x2 matrix-multiply controller's load/readout port. Accepts one job as an 8-byte valid/ready stream (A0..A3, then B0..B3), writes the bytes into the controller with its load strobes, and waits for the controller's `done` pulse. It then reads the four FP8 results through the output-select port and returns them as a 4-byte valid/ready stream with a last flag. It sits between the external host interface and the controller, one job in flight at a time.

## Interface
- `READ_DELAY`, default 2: idle cycles between the `ctrl_done` pulse and the first `output_en` cycle (1..15).
- `DONE_TIMEOUT`, default 16: cycles to wait in WAIT_DONE before abandoning the job (2..255).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  1  input byte valid.
- `s_ready`  out  1  input byte accepted when `s_valid && s_ready`.
- `s_data`  in  8  job byte.
- `load_en`  out  1  controller load strobe, registered.
- `load_sel_ab`  out  1  0 = A, 1 = B.
- `load_index`  out  2  element index.
- `load_data`  out  8  to controller `in_data`.
- `ctrl_done`  in  1  controller compute-done pulse.
- `output_en`  out  1  controller readout enable, registered.
- `output_sel`  out  2  result element select.
- `ctrl_out_data`  in  8  controller result byte, combinational from `output_sel`.
- `m_valid`  out  1  result byte valid.
- `m_ready`  in  1  result byte consumed when `m_valid && m_ready`.
- `m_data`  out  8  result byte.
- `m_last`  out  1  high with the 4th result byte.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse on done timeout.

## Operation
- States: IDLE, LOAD, WAIT_DONE, DELAY, READ, SEND.
- Byte counter `k`, 3 bits. Accepted byte k drives `load_sel_ab = k[2]`, `load_index = k[1:0]`, `load_data = s_data` on the next cycle, with `load_en = 1` for exactly that cycle.
- IDLE: `s_ready = 1`. The first accepted byte moves to LOAD, with `k` becoming 1.
- LOAD: `s_ready = 1` until 8 bytes have been accepted. Gaps in `s_valid` are allowed. After the 8th byte's `load_en` cycle, go to WAIT_DONE.
- WAIT_DONE: `s_ready = 0`, and a timeout counter runs.
  - `ctrl_done = 1`: go to DELAY.
  - Counter reaches `DONE_TIMEOUT` without `ctrl_done`: pulse `err` for 1 cycle and go to IDLE. The result buffer is unchanged and no output bytes are produced.
- `ctrl_done` in any state other than WAIT_DONE is ignored.
- DELAY: count `READ_DELAY` cycles, then go to READ.
- READ: `output_en = 1` for 4 consecutive cycles with `output_sel` = 0, 1, 2, 3. On each of those cycles, `ctrl_out_data` is captured into `buf[output_sel]` at the closing edge. `output_en` drops after sel 3, and the state goes to SEND.
- SEND: `m_valid = 1`, `m_data = buf[i]`, `m_last = (i == 3)`. `i` advances on each handshake. The handshake with `i == 3` returns to IDLE.
- `m_data` must stay stable while `m_valid && !m_ready`.
- The block never drives `load_en` and `output_en` in the same cycle.

## Timing
- Reset values:
  - Outputs: `s_ready`, `load_en`, `load_sel_ab`, `load_index`, `load_data`, `output_en`, `output_sel`, `m_valid`, `m_data`, `m_last`, `busy`, `err` are all 0.
  - Internal: state IDLE, `k` = 0, `buf` = 0.
- `s_ready` becomes 1 in the first cycle after `rst` deasserts.
- Gapless input with bytes accepted in cycles 0..7: `load_en` is high in cycles 1..8, and WAIT_DONE starts in cycle 9.
- `ctrl_done` high in cycle d:
  - DELAY occupies cycles d+1..d+`READ_DELAY`.
  - `output_en` is high in cycles d+`READ_DELAY`+1..d+`READ_DELAY`+4.
  - First `m_valid` is in cycle d+`READ_DELAY`+5.
- With `m_ready` held high, SEND lasts 4 cycles and `s_ready` reasserts on the following cycle.
- `ctrl_done` arriving in the same cycle the timeout expires counts as done: no `err`, go to DELAY.
- Asserting `rst` mid-job:
  - All outputs clear immediately, including `load_en` and `output_en`.
  - In-progress bytes and buffered results are discarded.
  - The controller must be reset alongside.

## Test plan
- Gapless job: bytes 0x11..0x18 -> `load_en` cycles 1..8 with (sel_ab, index) = (0,0),(0,1),(0,2),(0,3),(1,0),(1,1),(1,2),(1,3) and `load_data` 0x11..0x18. Controller stub pulses done 5 cycles later and returns `0x40 + output_sel` -> `m_data` 0x40, 0x41, 0x42, 0x43 with `m_last` only on 0x43.
- Input gaps: `s_valid` toggled 1,0,1,0… -> exactly 8 `load_en` pulses with the same (sel, index, data) sequence, and `s_ready` = 0 after the 8th acceptance until the job completes.
- Output backpressure: `m_ready` low for 3 cycles on the 2nd byte -> 0x41 held stable, no byte lost or duplicated, `busy` stays 1 until the 4th handshake.
- Timeout: stub never asserts done -> `err` = 1 for exactly one cycle `DONE_TIMEOUT` cycles after WAIT_DONE entry, no `output_en`, no `m_valid`, `s_ready` = 1 next cycle. Second case: done on the expiry cycle -> no `err`, normal readout.
- Reset mid-READ: `rst` pulsed during the 2nd `output_en` cycle -> all outputs 0 asynchronously. A following full job returns correct data.
- Spurious done: `ctrl_done` pulsed during LOAD -> ignored, and the block still waits for done in WAIT_DONE.
